// File: rtl/flash_audio_streamer.sv
// Flash-to-codec PCM streamer. A prefetching Avalon-MM reader fills a frame FIFO and a
// handshaking codec writer drains it; covers mono/stereo packing, attenuation and loop play.
module flash_audio_streamer #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned NUM_WORDS  = 1048576,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          STEREO     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [3:0]        atten,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underruns,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  input  logic              write_ready,
  output logic              write_s,
  output logic [15:0]       writedata_left,
  output logic [15:0]       writedata_right
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FPW   = STEREO ? 1 : 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {R_IDLE, R_REQ, R_DATA, R_PUSH0, R_PUSH1} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_ACK} w_state_e;

  r_state_e          r_state_q;
  w_state_e          w_state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q, busy_q, done_q, end_q, abort_pend_q;
  logic [31:0]       word_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ws_q, rdy_prev_q;
  logic [15:0]       left_q, right_q, underruns_q;

  logic        inflight_c, flush_c, start_ok_c, done_c, space_ok_c;
  logic        push_c, pop_c, last_push_c, underrun_c, fifo_empty_c;
  logic [15:0] sample_c;
  logic [31:0] frame_c;

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] sh);
    return 16'($signed(s) >>> sh);
  endfunction

  // A read already on the bus must complete before an abort can flush.
  always_comb begin
    fifo_empty_c = (count_q == '0);
    inflight_c   = (r_state_q == R_REQ) || (r_state_q == R_DATA);
    flush_c      = (abort && !inflight_c) ||
                   ((r_state_q == R_DATA) && flash_mem_readdatavalid && (abort || abort_pend_q));
    start_ok_c   = start && !abort && !busy_q;
    done_c       = busy_q && end_q && fifo_empty_c && (w_state_q == W_IDLE) && !abort;
    space_ok_c   = (count_q <= CNT_W'(FIFO_DEPTH - FPW));
    push_c       = ((r_state_q == R_PUSH0) || (r_state_q == R_PUSH1)) && !flush_c;
    last_push_c  = STEREO ? (r_state_q == R_PUSH0) : (r_state_q == R_PUSH1);
    pop_c        = (w_state_q == W_IDLE) && write_ready && !fifo_empty_c && !flush_c;
    underrun_c   = (w_state_q == W_IDLE) && busy_q && write_ready && !rdy_prev_q && fifo_empty_c;
    sample_c     = (r_state_q == R_PUSH1) ? word_q[31:16] : word_q[15:0];
    if (STEREO) frame_c = {scale(word_q[15:0], atten), scale(word_q[31:16], atten)};
    else        frame_c = {scale(sample_c, atten), scale(sample_c, atten)};
  end

  // Reader FSM and play control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q    <= R_IDLE;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      word_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      end_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_c) begin
        r_state_q    <= R_IDLE;
        addr_q       <= '0;
        rd_q         <= 1'b0;
        busy_q       <= 1'b0;
        end_q        <= 1'b0;
        abort_pend_q <= 1'b0;
      end else begin
        if (abort) abort_pend_q <= 1'b1;
        if (start_ok_c) begin
          busy_q <= 1'b1;
          end_q  <= 1'b0;
          addr_q <= '0;
        end
        if (done_c) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          end_q  <= 1'b0;
        end
        case (r_state_q)
          R_IDLE: if (busy_q && !end_q && space_ok_c) begin
            r_state_q <= R_REQ;
            rd_q      <= 1'b1;
          end
          R_REQ: if (!flash_mem_waitrequest) begin
            r_state_q <= R_DATA;
            rd_q      <= 1'b0;
          end
          R_DATA: if (flash_mem_readdatavalid) begin
            word_q    <= flash_mem_readdata;
            r_state_q <= R_PUSH0;
          end
          R_PUSH0, R_PUSH1: begin
            if (!last_push_c) begin
              r_state_q <= R_PUSH1;
            end else begin
              r_state_q <= R_IDLE;
              if (addr_q == LAST_ADDR) begin
                addr_q <= '0;
                if (!loop) end_q <= 1'b1;
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
              end
            end
          end
          default: r_state_q <= R_IDLE;
        endcase
      end
    end
  end

  // Frame FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= frame_c;
  end

  // Codec writer: the head is popped as the strobe is launched, so one accept = one pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      ws_q        <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      rdy_prev_q  <= 1'b0;
      underruns_q <= '0;
    end else begin
      rdy_prev_q <= write_ready;
      if (start_ok_c)                                 underruns_q <= '0;
      else if (underrun_c && underruns_q != 16'hFFFF) underruns_q <= underruns_q + 16'd1;
      case (w_state_q)
        W_IDLE: if (pop_c) begin
          ws_q      <= 1'b1;
          left_q    <= mem_q[rd_ptr_q][31:16];
          right_q   <= mem_q[rd_ptr_q][15:0];
          w_state_q <= W_SEND;
        end
        W_SEND: w_state_q <= W_ACK;
        W_ACK: if (!write_ready) begin
          ws_q      <= 1'b0;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign underruns         = underruns_q;
  assign flash_mem_read    = rd_q;
  assign flash_mem_address = addr_q;
  assign write_s           = ws_q;
  assign writedata_left    = left_q;
  assign writedata_right   = right_q;

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Bench for flash_audio_streamer: a mono (4-word) and a stereo (2-word) instance, each with
// a behavioural Avalon flash and a handshaking codec, checked against hand-computed values.
module tb_flash_audio_streamer;

  logic        clk, reset;
  logic [1:0]  start, abort, loop_s, busy, done, fread, waitreq, rvalid, wready, ws;
  logic [3:0]  atten [2];
  logic [7:0]  faddr [2];
  logic [31:0] rdata [2];
  logic [15:0] wl [2], wr [2], urun [2];

  logic [1:0]  starve, hold, man, man_rdy;
  int          wait_n [2], lat_n [2];
  logic [31:0] fmem [2][4];

  int          wcnt_w [2], lat_cnt [2], acc [2], vcnt [2], viol [2], wn [2], dn [2];
  logic [1:0]  pend, rd_wait, ws_prev, cod_rdy_q;
  logic [7:0]  paddr [2], wait_addr [2];
  logic [7:0]  alog [2][256];
  logic [31:0] wlog [2][256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          g;
    logic [3:0]  at;
    logic [31:0] word;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t        vt [6];
  logic [31:0] seq_b [8];

  flash_audio_streamer #(.ADDR_W(8), .NUM_WORDS(4), .FIFO_DEPTH(8), .STEREO(1'b0)) u_mono (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .loop(loop_s[0]),
    .atten(atten[0]), .busy(busy[0]), .done(done[0]), .underruns(urun[0]),
    .flash_mem_read(fread[0]), .flash_mem_address(faddr[0]),
    .flash_mem_waitrequest(waitreq[0]), .flash_mem_readdata(rdata[0]),
    .flash_mem_readdatavalid(rvalid[0]), .write_ready(wready[0]), .write_s(ws[0]),
    .writedata_left(wl[0]), .writedata_right(wr[0]));

  flash_audio_streamer #(.ADDR_W(8), .NUM_WORDS(2), .FIFO_DEPTH(8), .STEREO(1'b1)) u_st (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .loop(loop_s[1]),
    .atten(atten[1]), .busy(busy[1]), .done(done[1]), .underruns(urun[1]),
    .flash_mem_read(fread[1]), .flash_mem_address(faddr[1]),
    .flash_mem_waitrequest(waitreq[1]), .flash_mem_readdata(rdata[1]),
    .flash_mem_readdatavalid(rvalid[1]), .write_ready(wready[1]), .write_s(ws[1]),
    .writedata_left(wl[1]), .writedata_right(wr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      waitreq[g] = starve[g] | (fread[g] & (wcnt_w[g] < wait_n[g]));
      wready[g]  = man[g] ? man_rdy[g] : (~hold[g] & cod_rdy_q[g]);
    end
  end

  // Flash slave, codec sink and bookkeeping for both instances.
  always @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        wcnt_w[g] <= 0; lat_cnt[g] <= 0; acc[g] <= 0; vcnt[g] <= 0; viol[g] <= 0;
        wn[g] <= 0; dn[g] <= 0; paddr[g] <= '0; wait_addr[g] <= '0; rdata[g] <= '0;
      end
      pend <= '0; rd_wait <= '0; ws_prev <= '0; cod_rdy_q <= '0; rvalid <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        rvalid[g] <= 1'b0;
        if (fread[g] && !waitreq[g]) begin
          pend[g]       <= 1'b1;
          lat_cnt[g]    <= lat_n[g];
          paddr[g]      <= faddr[g];
          wcnt_w[g]     <= 0;
          alog[g][acc[g]] <= faddr[g];
          acc[g]        <= acc[g] + 1;
        end else if (fread[g]) begin
          wcnt_w[g] <= wcnt_w[g] + 1;
        end
        if (pend[g]) begin
          if (lat_cnt[g] <= 1) begin
            rvalid[g] <= 1'b1;
            rdata[g]  <= fmem[g][paddr[g][1:0]];
            pend[g]   <= 1'b0;
            vcnt[g]   <= vcnt[g] + 1;
          end else begin
            lat_cnt[g] <= lat_cnt[g] - 1;
          end
        end
        if (rd_wait[g] && (!fread[g] || faddr[g] != wait_addr[g])) viol[g] <= viol[g] + 1;
        rd_wait[g]   <= fread[g] & waitreq[g];
        wait_addr[g] <= faddr[g];
        if (ws[g] && !ws_prev[g]) begin
          wlog[g][wn[g]] <= {wl[g], wr[g]};
          wn[g]          <= wn[g] + 1;
        end
        ws_prev[g]   <= ws[g];
        cod_rdy_q[g] <= ~(ws[g] & wready[g]);
        if (done[g]) dn[g] <= dn[g] + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1; tick(1); start[g] = 1'b0;
  endtask

  task automatic play(input int g, input logic [3:0] at);
    atten[g] = at; loop_s[g] = 1'b0;
    pulse_start(g);
    for (int i = 0; i < 3000 && busy[g]; i++) tick(1);
    check("play_finished", 64'(!busy[g]), 64'd1);
    tick(5);
  endtask

  initial begin
    int   bw, bd, bacc, bv;
    logic got;
    reset = 1'b1;
    start = '0; abort = '0; loop_s = '0; starve = '0; hold = '0; man = '0; man_rdy = '0;
    for (int g = 0; g < 2; g++) begin
      atten[g] = '0; wait_n[g] = 0; lat_n[g] = 1;
      for (int k = 0; k < 4; k++) fmem[g][k] = '0;
    end
    vt[0] = '{0, 4'd0,  32'h0002_FFFE, 32'hFFFE_FFFE, 32'h0002_0002};
    vt[1] = '{1, 4'd6,  32'h8000_4000, 32'h0100_FE00, 32'h0100_FE00};
    vt[2] = '{0, 4'd15, 32'h7FFF_8000, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[3] = '{0, 4'd4,  32'h1234_F00F, 32'hFF00_FF00, 32'h0123_0123};
    vt[4] = '{1, 4'd0,  32'hABCD_1234, 32'h1234_ABCD, 32'h1234_ABCD};
    vt[5] = '{1, 4'd1,  32'h0001_FFFF, 32'hFFFF_0000, 32'hFFFF_0000};
    seq_b = '{32'hFFFE_FFFE, 32'h0002_0002, 32'h0003_0003, 32'h0004_0004,
              32'h8000_8000, 32'h7FFF_7FFF, 32'h0000_0000, 32'h0001_0001};
    tick(3);
    reset = 1'b0;
    tick(2);

    // Reset state
    check("rst_ctrl", 64'({busy, done, fread, ws}), 64'd0);
    check("rst_urun", 64'({urun[0], urun[1]}), 64'd0);
    check("rst_addr", 64'({faddr[0], faddr[1]}), 64'd0);
    check("rst_wdata", 64'({wl[0], wr[0], wl[1], wr[1]}), 64'd0);

    // Packing and attenuation table
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) fmem[vt[v].g][k] = vt[v].word;
      bw = wn[vt[v].g]; bd = dn[vt[v].g];
      play(vt[v].g, vt[v].at);
      check("vec_first", 64'(wlog[vt[v].g][bw]), 64'(vt[v].e0));
      check("vec_second", 64'(wlog[vt[v].g][bw + 1]), 64'(vt[v].e1));
      check("vec_nwrites", 64'(wn[vt[v].g] - bw), (vt[v].g == 0) ? 64'd8 : 64'd2);
      check("vec_done", 64'(dn[vt[v].g] - bd), 64'd1);
    end

    // Slow flash: waitrequest 5 cycles, data 3 cycles after accept
    fmem[0][0] = 32'h0002_FFFE; fmem[0][1] = 32'h0004_0003;
    fmem[0][2] = 32'h7FFF_8000; fmem[0][3] = 32'h0001_0000;
    wait_n[0] = 5; lat_n[0] = 3;
    bw = wn[0]; bacc = acc[0]; bv = vcnt[0];
    play(0, 4'd0);
    check("b_reads", 64'(acc[0] - bacc), 64'd4);
    check("b_valids", 64'(vcnt[0] - bv), 64'd4);
    check("b_nwrites", 64'(wn[0] - bw), 64'd8);
    check("b_read_stable", 64'(viol[0]), 64'd0);
    for (int k = 0; k < 8; k++) check("b_frame", 64'(wlog[0][bw + k]), 64'(seq_b[k]));
    wait_n[0] = 0; lat_n[0] = 1;

    // Codec back-pressure: FIFO fills, reader stalls, then drains in order
    hold[0] = 1'b1; loop_s[0] = 1'b1; atten[0] = '0;
    bw = wn[0]; bacc = acc[0];
    pulse_start(0);
    tick(100);
    check("c_reads_at_full", 64'(acc[0] - bacc), 64'd4);
    check("c_reader_stalled", 64'(fread[0]), 64'd0);
    check("c_no_writes", 64'(wn[0] - bw), 64'd0);
    hold[0] = 1'b0;
    for (int i = 0; i < 3000 && (wn[0] - bw) < 20; i++) tick(1);
    check("c_progress", 64'((wn[0] - bw) >= 20), 64'd1);
    abort[0] = 1'b1; tick(1); abort[0] = 1'b0;
    tick(10);
    check("c_abort_busy", 64'(busy[0]), 64'd0);
    for (int k = 0; k < 20; k++) check("c_frame", 64'(wlog[0][bw + k]), 64'(seq_b[k % 8]));

    // Loop play on the 2-word stereo clip
    fmem[1][0] = 32'hAAAA_1111; fmem[1][1] = 32'hBBBB_2222;
    fmem[1][2] = 32'hAAAA_1111; fmem[1][3] = 32'hBBBB_2222;
    loop_s[1] = 1'b1; atten[1] = '0;
    bacc = acc[1]; bd = dn[1];
    pulse_start(1);
    for (int i = 0; i < 2000 && (acc[1] - bacc) < 6; i++) tick(1);
    for (int k = 0; k < 4; k++) check("d_addr", 64'(alog[1][bacc + k]), 64'(k % 2));
    check("d_no_done", 64'(dn[1] - bd), 64'd0);
    check("d_busy", 64'(busy[1]), 64'd1);
    abort[1] = 1'b1; tick(1); abort[1] = 1'b0;
    tick(10);
    check("d_abort_busy", 64'(busy[1]), 64'd0);

    // Starved flash with three codec slots, then abort during the data phase
    man[1] = 1'b1; man_rdy[1] = 1'b0; starve[1] = 1'b1; lat_n[1] = 3;
    bd = dn[1];
    pulse_start(1);
    tick(5);
    check("e_read_held", 64'(fread[1]), 64'd1);
    repeat (3) begin
      man_rdy[1] = 1'b1; tick(2); man_rdy[1] = 1'b0; tick(2);
    end
    check("e_underruns", 64'(urun[1]), 64'd3);
    bacc = acc[1]; bw = wn[1];
    starve[1] = 1'b0; tick(1);
    check("e_accepted", 64'(acc[1] - bacc), 64'd1);
    abort[1] = 1'b1; tick(1); abort[1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid[1]) got = 1'b1;
      else tick(1);
    end
    check("e_valid_seen", 64'(got), 64'd1);
    check("e_busy_at_valid", 64'(busy[1]), 64'd1);
    tick(1);
    check("e_busy_after_valid", 64'(busy[1]), 64'd0);
    man[1] = 1'b0;
    tick(20);
    check("e_word_discarded", 64'(wn[1] - bw), 64'd0);
    check("e_no_done", 64'(dn[1] - bd), 64'd0);
    check("e_urun_kept", 64'(urun[1]), 64'd3);
    bacc = acc[1]; bw = wn[1];
    play(1, 4'd0);
    check("e_replay_addr", 64'(alog[1][bacc]), 64'd0);
    check("e_replay_frame", 64'(wlog[1][bw]), 64'h1111_AAAA);

    // Start and abort together: abort wins
    start[1] = 1'b1; abort[1] = 1'b1; tick(1);
    start[1] = 1'b0; abort[1] = 1'b0; tick(2);
    check("f_start_abort", 64'(busy[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
